// File: rtl/xgri_pkg.sv
// xgri_gen3 shared definitions: register map, status/CFG bit positions
// and the per-channel control bundle decoded by the top level.
package xgri_pkg;

    // Global registers
    localparam logic [4:0] REG_STATUS  = 5'd0;
    localparam logic [4:0] REG_HSCROLL = 5'd1;
    localparam logic [4:0] REG_VSCROLL = 5'd2;

    // Channel register block: CH_BASE + CH_STRIDE*c + CH_*
    localparam int CH_BASE   = 8;
    localparam int CH_STRIDE = 4;

    localparam logic [1:0] CH_ADDR = 2'd0;
    localparam logic [1:0] CH_INC  = 2'd1;
    localparam logic [1:0] CH_DATA = 2'd2;
    localparam logic [1:0] CH_CFG  = 2'd3;

    // Status register layout
    localparam int ST_BUSY_BIT  = 15;
    localparam int ST_FULL_LSB  = 4;
    localparam int ST_EMPTY_LSB = 0;

    // CFG register layout
    localparam int CFG_BL_LSB    = 0;
    localparam int CFG_LVL_LSB   = 2;
    localparam int CFG_FLUSH_BIT = 15;

    // Per-channel strobes produced by the register decoder
    typedef struct packed {
        logic addr_wr;
        logic inc_wr;
        logic push;
        logic cfg_wr;
        logic cfg_rd;
    } chan_ctl_t;

endpackage

// File: rtl/xgri_chan.sv
// One xgri write channel: show-ahead FIFO, overflow flag and address generator.
// Ports: clk_sys/rst_n, ctl strobes + wdata from decoder, pop from XGMM,
//   FIFO flags/head word, addr/inc/burst_log2/level/ovf for readback.
module xgri_chan
    import xgri_pkg::*;
#(
    parameter int DW    = 16,
    parameter int AW    = 15,
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  chan_ctl_t     ctl,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head,
    output logic [AW-1:0] addr,
    output logic [AW-1:0] inc,
    output logic [1:0]    burst_log2,
    output logic [LW-1:0] level,
    output logic          ovf
);

    logic [DW-1:0] mem [DEPTH];
    logic [LW-1:0] wptr;
    logic [LW-1:0] rptr;
    logic [2:0]    bcnt;
    logic [2:0]    bmax;
    logic          flush;
    logic          push_ok;
    logic          pop_ok;

    // Pointers carry one extra wrap bit so full and empty differ.
    assign level   = wptr - rptr;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign head    = mem[rptr[LW-2:0]];

    assign flush   = ctl.cfg_wr & wdata[CFG_FLUSH_BIT];
    // Push checks full before any same-cycle pop frees a slot.
    assign push_ok = ctl.push & ~full;
    assign pop_ok  = pop & ~empty;
    assign bmax    = (3'd1 << burst_log2) - 3'd1;

    always_ff @(posedge clk_sys) begin
        if (push_ok && !flush) begin
            mem[wptr[LW-2:0]] <= wdata;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            ovf        <= 1'b0;
            addr       <= '0;
            inc        <= AW'(1);
            burst_log2 <= '0;
            bcnt       <= '0;
        end else begin
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push_ok) wptr <= wptr + 1'b1;
                if (pop_ok)  rptr <= rptr + 1'b1;
            end

            // A CFG read reports the old value and clears it on the same edge.
            if (flush || ctl.cfg_rd) begin
                ovf <= 1'b0;
            end else if (ctl.push && full) begin
                ovf <= 1'b1;
            end

            if (ctl.cfg_wr) burst_log2 <= wdata[CFG_BL_LSB +: 2];
            if (ctl.inc_wr) inc <= wdata[AW-1:0];

            // CPU address load beats the burst increment.
            if (ctl.addr_wr) begin
                addr <= wdata[AW-1:0];
                bcnt <= '0;
            end else if (flush) begin
                bcnt <= '0;
            end else if (pop_ok) begin
                if (bcnt == bmax) begin
                    addr <= addr + inc;
                    bcnt <= '0;
                end else begin
                    bcnt <= bcnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/xgri_gen3.sv
// xgri_gen3 top: CPU register decode, scroll registers, busy and read mux
// around NCH xgri_chan write channels feeding XGMM (m_pop/m_data/m_addr).
module xgri_gen3
    import xgri_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DW    = 16,
    parameter int AW    = 15,
    parameter int DEPTH = 16,
    parameter int HSW   = 11,
    parameter int VSW   = 10
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              ri_en,
    input  logic              ri_wren,
    input  logic              ri_ren,
    input  logic [4:0]        ri_addr,
    input  logic [DW-1:0]     from_cpu,
    output logic [DW-1:0]     to_cpu,
    output logic [HSW-1:0]    ri_h_scroll,
    output logic [VSW-1:0]    ri_v_scroll,
    input  logic [NCH-1:0]    m_pop,
    output logic [NCH-1:0]    m_full,
    output logic [NCH-1:0]    m_empty,
    output logic [NCH*DW-1:0] m_data,
    output logic [NCH*AW-1:0] m_addr
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic          wr;
    logic          rd;
    logic          in_ch;
    logic [2:0]    idx;
    logic [1:0]    sel;
    logic          busy;
    logic [DW-1:0] status;
    logic [DW-1:0] ch_rdata;
    logic [DW-1:0] rdata;

    logic [NCH-1:0] ch_hit;
    logic [NCH-1:0] push_v;
    logic [NCH-1:0] ovf_v;
    chan_ctl_t      ctl   [NCH];
    logic [AW-1:0]  addr_a[NCH];
    logic [AW-1:0]  inc_a [NCH];
    logic [1:0]     bl_a  [NCH];
    logic [LW-1:0]  lvl_a [NCH];

    assign wr    = ri_en & ri_wren;
    assign rd    = ri_en & ri_ren;
    // Addresses 8..31 are the channel area; idx is the channel number.
    assign in_ch = ri_addr[4] | ri_addr[3];
    assign idx   = ri_addr[4:2] - 3'(CH_BASE / CH_STRIDE);
    assign sel   = ri_addr[1:0];

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign ch_hit[c] = in_ch & (idx == 3'(c));
        assign ctl[c] = '{
            addr_wr: wr & ch_hit[c] & (sel == CH_ADDR),
            inc_wr:  wr & ch_hit[c] & (sel == CH_INC),
            push:    wr & ch_hit[c] & (sel == CH_DATA),
            cfg_wr:  wr & ch_hit[c] & (sel == CH_CFG),
            cfg_rd:  rd & ch_hit[c] & (sel == CH_CFG)
        };
        assign push_v[c] = ctl[c].push;

        xgri_chan #(
            .DW    (DW),
            .AW    (AW),
            .DEPTH (DEPTH),
            .LW    (LW)
        ) u_chan (
            .clk_sys    (clk_sys),
            .rst_n      (rst_n),
            .ctl        (ctl[c]),
            .wdata      (from_cpu),
            .pop        (m_pop[c]),
            .full       (m_full[c]),
            .empty      (m_empty[c]),
            .head       (m_data[c*DW +: DW]),
            .addr       (addr_a[c]),
            .inc        (inc_a[c]),
            .burst_log2 (bl_a[c]),
            .level      (lvl_a[c]),
            .ovf        (ovf_v[c])
        );

        assign m_addr[c*AW +: AW] = addr_a[c];
    end

    // Flags lag a push by one cycle; busy masks them meanwhile.
    always_comb begin
        status = '0;
        status[ST_BUSY_BIT] = busy;
        for (int c = 0; c < NCH; c++) begin
            status[ST_FULL_LSB + c]  = m_full[c] | busy;
            status[ST_EMPTY_LSB + c] = m_empty[c] & ~busy;
        end
    end

    always_comb begin
        ch_rdata = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_hit[c]) begin
                unique case (sel)
                    CH_ADDR: ch_rdata = DW'(addr_a[c]);
                    CH_INC:  ch_rdata = DW'(inc_a[c]);
                    CH_CFG: begin
                        ch_rdata[DW-1]               = ovf_v[c];
                        ch_rdata[CFG_LVL_LSB +: LW]  = lvl_a[c];
                        ch_rdata[CFG_BL_LSB +: 2]    = bl_a[c];
                    end
                    default: ch_rdata = '0;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            (ri_addr == REG_STATUS):  rdata = status;
            (ri_addr == REG_HSCROLL): rdata = DW'(ri_h_scroll);
            (ri_addr == REG_VSCROLL): rdata = DW'(ri_v_scroll);
            (|ch_hit):                rdata = ch_rdata;
            default:                  rdata = '0;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            to_cpu      <= '0;
            ri_h_scroll <= '0;
            ri_v_scroll <= '0;
            busy        <= 1'b0;
        end else begin
            busy <= |push_v;
            if (rd) to_cpu <= rdata;
            if (wr && ri_addr == REG_HSCROLL) ri_h_scroll <= from_cpu[HSW-1:0];
            if (wr && ri_addr == REG_VSCROLL) ri_v_scroll <= from_cpu[VSW-1:0];
        end
    end

endmodule
